muldiv_unit: RTL

//  Iterative RV32M multiply/divide unit, parametrised in XLEN. It sits beside the single-cycle
//  ALU in the execute stage. Execute hands off M-extension ops via valid/ready, stalls, and

---
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready request and response.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier path.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_op_i,
    input  logic [XLEN-1:0] req_a_i,
    input  logic [XLEN-1:0] req_b_i,
    input  logic [4:0]      req_rd_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_data_o,
    output logic [4:0]      resp_rd_o
);

    localparam int CNTW = $clog2(XLEN+1);
    localparam int W2   = 2*XLEN;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nx;
    logic [CNTW-1:0]   cnt;
    logic [2:0]        op;
    logic [4:0]        rd_q;
    logic              neg_q, neg_r;
    logic [XLEN-1:0]   opnd;
    logic [W2-1:0]     acc;

    logic              accept, is_div, sa, sb;
    logic              div_zero, ovf, special_hit;
    logic [XLEN-1:0]   a_mag, b_mag, special_data;
    logic [XLEN:0]     sum, rp;
    logic [XLEN-1:0]   diff, q_abs, r_abs, busy_data;
    logic              ge;
    logic [W2-1:0]     acc_step, prod;

    // Request decode: signedness, magnitudes and the BUSY-skipping cases
    always_comb begin
        is_div       = req_op_i[2];
        sa           = req_a_i[XLEN-1] & (req_op_i == 3'd1 || req_op_i == 3'd2 ||
                                          req_op_i == 3'd4 || req_op_i == 3'd6);
        sb           = req_b_i[XLEN-1] & (req_op_i == 3'd1 || req_op_i == 3'd4 ||
                                          req_op_i == 3'd6);
        a_mag        = sa ? -req_a_i : req_a_i;
        b_mag        = sb ? -req_b_i : req_b_i;
        div_zero     = is_div && (req_b_i == '0);
        ovf          = !req_op_i[0] && is_div && (req_b_i == '1) &&
                       (req_a_i == {1'b1, {(XLEN-1){1'b0}}});
        special_hit  = div_zero || ovf;
        special_data = '0;
        if (div_zero)
            special_data = req_op_i[1] ? req_a_i : '1;
        else if (ovf)
            special_data = req_op_i[1] ? '0 : req_a_i;
`ifdef MULDIV_FAST_MUL_EN
        begin
            logic signed [W2-1:0] fa, fb, fp;
            fa = W2'($signed({sa, req_a_i}));
            fb = W2'($signed({sb, req_b_i}));
            fp = fa * fb;
            if (!is_div) begin
                special_hit  = 1'b1;
                special_data = (req_op_i == 3'd0) ? fp[XLEN-1:0] : fp[W2-1:XLEN];
            end
        end
`endif
    end

    // One iteration: shift-add multiply or restoring divide step
    always_comb begin
        sum  = {1'b0, acc[W2-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        rp   = acc[W2-1:XLEN-1];
        ge   = rp >= {1'b0, opnd};
        diff = rp[XLEN-1:0] - opnd;
        if (op[2])
            acc_step = {(ge ? diff : rp[XLEN-1:0]), acc[XLEN-2:0], ge};
        else
            acc_step = {sum, acc[XLEN-1:1]};
        prod  = neg_q ? -acc_step : acc_step;
        q_abs = acc_step[XLEN-1:0];
        r_abs = acc_step[W2-1:XLEN];
        if (op[2])
            busy_data = op[1] ? (neg_r ? -r_abs : r_abs)
                              : (neg_q ? -q_abs : q_abs);
        else
            busy_data = (op == 3'd0) ? prod[XLEN-1:0] : prod[W2-1:XLEN];
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE: if (req_valid_i && !flush_i) begin
                accept   = 1'b1;
                state_nx = special_hit ? DONE : BUSY;
            end
            BUSY: if (cnt == '0) state_nx = DONE;
            DONE: if (resp_ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush_i)
            state_nx = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            resp_rd_o    <= '0;
            cnt          <= '0;
            op           <= '0;
            rd_q         <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            opnd         <= '0;
            acc          <= '0;
        end else begin
            state        <= state_nx;
            req_ready_o  <= (state_nx == IDLE);
            resp_valid_o <= (state_nx == DONE);
            if (accept) begin
                op    <= req_op_i;
                rd_q  <= req_rd_i;
                neg_q <= sa ^ sb;
                neg_r <= sa;
                cnt   <= CNTW'(XLEN-1);
                opnd  <= is_div ? b_mag : a_mag;
                acc   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                if (special_hit) begin
                    resp_data_o <= special_data;
                    resp_rd_o   <= req_rd_i;
                end
            end
            if (state == BUSY) begin
                acc <= acc_step;
                if (cnt != '0)
                    cnt <= cnt - 1'b1;
                else if (!flush_i) begin
                    resp_data_o <= busy_data;
                    resp_rd_o   <= rd_q;
                end
            end
        end
    end

endmodule
